// File: rtl/ocimem_access_arbiter.sv
// Two-requester round-robin arbiter in front of the single-port OCI debug RAM.
// One access in flight at a time; read data is registered into the owner's rdata.
module ocimem_access_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r0_wr,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_wr,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  // Handshake: a requester holds req and its fields stable until its one-cycle
  // gnt; req is sampled only in IDLE, and a sampled access always completes.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);

  state_t            r_state;
  state_t            w_next_state;
  logic              r_owner;
  logic              r_wr;
  logic              r_last_owner;
  logic [2:0]        r_cnt;
  logic              r_r0_gnt, r_r1_gnt, r_r0_rvalid, r_r1_rvalid;
  logic [DATA_W-1:0] r_r0_rdata, r_r1_rdata;
  logic              r_mem_cs, r_mem_we, r_busy;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic              w_any_req, w_pick, w_sel_wr, w_capture;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_cs_n, w_we_n, w_gnt0_n, w_gnt1_n, w_rv0_n, w_rv1_n, w_busy_n;
  logic [ADDR_W-1:0] w_addr_n;
  logic [DATA_W-1:0] w_wdata_n;

  // On a tie the requester that did not own the previous access wins.
  assign w_any_req   = r0_req | r1_req;
  assign w_pick      = r1_req & (~r0_req | ~r_last_owner);
  assign w_sel_wr    = w_pick ? r1_wr    : r0_wr;
  assign w_sel_addr  = w_pick ? r1_addr  : r0_addr;
  assign w_sel_wdata = w_pick ? r1_wdata : r0_wdata;
  assign w_capture   = (r_state == S_WAIT) && (r_cnt == 3'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_next_state = S_ISSUE;
      S_ISSUE: w_next_state = r_wr ? S_IDLE : S_WAIT;
      S_WAIT:  if (r_cnt == 3'd0) w_next_state = S_RESP;
      S_RESP:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; the ISSUE cycle is only entered from IDLE.
  always_comb begin
    w_cs_n    = (r_state == S_IDLE) && w_any_req;
    w_we_n    = w_cs_n & w_sel_wr;
    w_addr_n  = w_cs_n ? w_sel_addr : '0;
    w_wdata_n = w_cs_n ? w_sel_wdata : '0;
    w_gnt0_n  = w_cs_n & ~w_pick;
    w_gnt1_n  = w_cs_n & w_pick;
    w_rv0_n   = w_capture & ~r_owner;
    w_rv1_n   = w_capture & r_owner;
    w_busy_n  = (w_next_state != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner      <= 1'b0;
      r_wr         <= 1'b0;
      r_last_owner <= 1'b1;
      r_cnt        <= 3'd0;
      r_r0_gnt     <= 1'b0;
      r_r1_gnt     <= 1'b0;
      r_r0_rvalid  <= 1'b0;
      r_r1_rvalid  <= 1'b0;
      r_r0_rdata   <= '0;
      r_r1_rdata   <= '0;
      r_mem_cs     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_busy       <= 1'b0;
    end else begin
      if (w_cs_n) begin
        r_owner      <= w_pick;
        r_wr         <= w_sel_wr;
        r_last_owner <= w_pick;
      end
      if (r_state == S_ISSUE && !r_wr)       r_cnt <= LAT_LOAD;
      else if (r_state == S_WAIT && r_cnt != 3'd0) r_cnt <= r_cnt - 3'd1;
      if (w_capture && !r_owner) r_r0_rdata <= mem_rdata;
      if (w_capture &&  r_owner) r_r1_rdata <= mem_rdata;
      r_r0_gnt    <= w_gnt0_n;
      r_r1_gnt    <= w_gnt1_n;
      r_r0_rvalid <= w_rv0_n;
      r_r1_rvalid <= w_rv1_n;
      r_mem_cs    <= w_cs_n;
      r_mem_we    <= w_we_n;
      r_mem_addr  <= w_addr_n;
      r_mem_wdata <= w_wdata_n;
      r_busy      <= w_busy_n;
    end
  end

  assign r0_gnt    = r_r0_gnt;
  assign r1_gnt    = r_r1_gnt;
  assign r0_rvalid = r_r0_rvalid;
  assign r1_rvalid = r_r1_rvalid;
  assign r0_rdata  = r_r0_rdata;
  assign r1_rdata  = r_r1_rdata;
  assign mem_cs    = r_mem_cs;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_ocimem_access_arbiter.sv
// Scoreboarded bench for ocimem_access_arbiter: a RD_LAT=2 instance under directed
// traffic, plus RD_LAT=1 and RD_LAT=7 instances running back-to-back reads.
module tb_ocimem_access_arbiter;

  localparam int LAT = 2;
  localparam int EW  = 59;  // {cycle[15:0], kind, owner, we, addr[7:0], data[31:0]}

  logic        clk = 1'b0;
  logic        reset;
  logic        r0_req, r0_wr, r1_req, r1_wr;
  logic [7:0]  r0_addr, r1_addr;
  logic [31:0] r0_wdata, r1_wdata;
  logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
  logic [31:0] r0_rdata, r1_rdata;
  logic        mem_cs, mem_we, busy;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [1:0]  dbg_state;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  logic [31:0] mem_m [256];
  logic [31:0] pipe [LAT];

  ocimem_access_arbiter #(.ADDR_W(8), .DATA_W(32), .RD_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_wr(r0_wr), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_wr(r1_wr), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: data read at mem_cs cycle c is valid during cycle c+LAT; filler otherwise.
  always @(posedge clk) begin
    if (mem_cs && mem_we) mem_m[mem_addr] <= mem_wdata;
    pipe[0] <= (mem_cs && !mem_we) ? mem_m[mem_addr] : (32'hBAD00000 | 32'(cyc));
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[LAT-1];

  function automatic logic [EW-1:0] ev(input int c, input logic kind, input logic owner,
                                       input logic we, input logic [7:0] addr,
                                       input logic [31:0] data);
    logic [15:0] c16;
    c16 = c[15:0];
    return {c16, kind, owner, we, addr, data};
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic sb_cmp(input string name, input logic have, input logic [EW-1:0] got,
                        input logic [EW-1:0] exp);
    checks++;
    if (!have) begin
      errors++;
      $display("FAIL %s: unexpected event got=%h, nothing expected", name, got);
    end else if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic sb_missing(input string name, input logic [EW-1:0] exp);
    checks++;
    errors++;
    $display("FAIL %s: expected event %h never seen", name, exp);
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!reset) begin
      while (exp_q.size() > 0 && exp_q[0][EW-1 -: 16] < 16'(cyc))
        sb_missing("main_missing", exp_q.pop_front());
      if (r0_gnt || r1_gnt) begin
        if (exp_q.size() > 0)
          sb_cmp("main_gnt", 1'b1, ev(cyc, 1'b0, r1_gnt, mem_we, mem_addr, mem_wdata), exp_q.pop_front());
        else
          sb_cmp("main_gnt", 1'b0, ev(cyc, 1'b0, r1_gnt, mem_we, mem_addr, mem_wdata), '0);
      end
      if (r0_rvalid || r1_rvalid) begin
        if (exp_q.size() > 0)
          sb_cmp("main_rvalid", 1'b1, ev(cyc, 1'b1, r1_rvalid, 1'b0, 8'h00, r1_rvalid ? r1_rdata : r0_rdata),
                 exp_q.pop_front());
        else
          sb_cmp("main_rvalid", 1'b0, ev(cyc, 1'b1, r1_rvalid, 1'b0, 8'h00, r1_rvalid ? r1_rdata : r0_rdata), '0);
      end
      checks++;
      if ((r0_gnt && r1_gnt) || (r0_rvalid && r1_rvalid) ||
          ((r0_gnt || r1_gnt) && (r0_rvalid || r1_rvalid)) ||
          (mem_we && !mem_cs) || (mem_cs != (r0_gnt || r1_gnt))) begin
        errors++;
        $display("FAIL invariant: cyc=%0d gnt=%b%b rvalid=%b%b cs=%b we=%b",
                 cyc, r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_cs, mem_we);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 40) begin
      next_cycle();
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
    end
  endtask

  // Raise req in the current (IDLE) cycle n, queue its expected events, drop req at n+1.
  task automatic issue(input logic who, input logic wr, input logic [7:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rexp);
    int n;
    n = cyc;
    if (who) begin
      r1_req = 1'b1; r1_wr = wr; r1_addr = addr; r1_wdata = wdata;
    end else begin
      r0_req = 1'b1; r0_wr = wr; r0_addr = addr; r0_wdata = wdata;
    end
    exp_q.push_back(ev(n + 1, 1'b0, who, wr, addr, wdata));
    if (!wr) exp_q.push_back(ev(n + 2 + LAT, 1'b1, who, 1'b0, 8'h00, rexp));
    next_cycle();
    if (who) r1_req = 1'b0;
    else     r0_req = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctrl"}, {57'd0, r0_gnt, r0_rvalid, r1_gnt, r1_rvalid, mem_cs, mem_we, busy}, 64'd0);
    check({name, "_r0_rdata"}, {32'd0, r0_rdata}, 64'd0);
    check({name, "_r1_rdata"}, {32'd0, r1_rdata}, 64'd0);
    check({name, "_mem_bus"}, {24'd0, mem_addr, mem_wdata}, 64'd0);
  endtask

  // ---------------- RD_LAT = 1 and 7 instances ----------------
  for (genvar g = 0; g < 2; g++) begin : g_lat
    localparam int L = (g == 0) ? 1 : 7;
    logic          l_req;
    logic          gnt0, rv0, gnt1, rv1, cs, we, bsy;
    logic [7:0]    maddr;
    logic [31:0]   rd0, rd1, mwd, mrd;
    logic [1:0]    st;
    logic [31:0]   lpipe [L];
    logic [EW-1:0] lq[$];
    bit            done = 1'b0;

    ocimem_access_arbiter #(.ADDR_W(8), .DATA_W(32), .RD_LAT(L)) dut_l (
      .clk(clk), .reset(reset),
      .r0_req(l_req), .r0_wr(1'b0), .r0_addr(8'h05), .r0_wdata(32'h0),
      .r0_gnt(gnt0), .r0_rvalid(rv0), .r0_rdata(rd0),
      .r1_req(1'b0), .r1_wr(1'b0), .r1_addr(8'h00), .r1_wdata(32'h0),
      .r1_gnt(gnt1), .r1_rvalid(rv1), .r1_rdata(rd1),
      .mem_cs(cs), .mem_we(we), .mem_addr(maddr), .mem_wdata(mwd),
      .mem_rdata(mrd), .busy(bsy), .dbg_state(st)
    );

    always @(posedge clk) begin
      lpipe[0] <= (cs && !we) ? (32'hC0DE0000 | {24'h0, maddr}) : (32'hBAD00000 | 32'(cyc));
      for (int i = 1; i < L; i++) lpipe[i] <= lpipe[i-1];
    end
    assign mrd = lpipe[L-1];

    always @(negedge clk) begin
      if (!reset) begin
        while (lq.size() > 0 && lq[0][EW-1 -: 16] < 16'(cyc))
          sb_missing($sformatf("lat%0d_missing", L), lq.pop_front());
        if (gnt0 || gnt1) begin
          if (lq.size() > 0)
            sb_cmp($sformatf("lat%0d_gnt", L), 1'b1, ev(cyc, 1'b0, gnt1, we, maddr, mwd), lq.pop_front());
          else
            sb_cmp($sformatf("lat%0d_gnt", L), 1'b0, ev(cyc, 1'b0, gnt1, we, maddr, mwd), '0);
        end
        if (rv0 || rv1) begin
          if (lq.size() > 0)
            sb_cmp($sformatf("lat%0d_rvalid", L), 1'b1, ev(cyc, 1'b1, rv1, 1'b0, 8'h00, rd0), lq.pop_front());
          else
            sb_cmp($sformatf("lat%0d_rvalid", L), 1'b0, ev(cyc, 1'b1, rv1, 1'b0, 8'h00, rd0), '0);
        end
        checks++;
        if (cs != gnt0) begin
          errors++;
          $display("FAIL lat%0d_cs: cyc=%0d mem_cs=%b gnt=%b", L, cyc, cs, gnt0);
        end
      end
    end

    // Three back-to-back r0 reads: each new access is sampled 3+L cycles after the previous.
    initial begin
      int n;
      l_req = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      n = cyc;
      l_req = 1'b1;
      for (int k = 0; k < 3; k++) begin
        lq.push_back(ev(n + k * (3 + L) + 1, 1'b0, 1'b0, 1'b0, 8'h05, 32'h0));
        lq.push_back(ev(n + k * (3 + L) + 2 + L, 1'b1, 1'b0, 1'b0, 8'h00, 32'hC0DE0005));
      end
      repeat (2 * (3 + L) + 1) begin
        @(posedge clk);
        #1;
      end
      l_req = 1'b0;
      repeat (L + 6) begin
        @(posedge clk);
        #1;
      end
      checks++;
      if (lq.size() != 0) begin
        errors++;
        $display("FAIL lat%0d_drain: %0d events left, required 0", L, lq.size());
      end
      done = 1'b1;
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int n;
    reset = 1'b1;
    r0_req = 1'b0; r0_wr = 1'b0; r0_addr = 8'h00; r0_wdata = 32'h0;
    r1_req = 1'b0; r1_wr = 1'b0; r1_addr = 8'h00; r1_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    next_cycle();
    check_all_zero("reset");

    // r0 write: gnt/mem_cs one cycle after sampling, idle again the cycle after.
    issue(1'b0, 1'b1, 8'h10, 32'hDEADBEEF, 32'h0);
    check("wr_busy_issue", {63'd0, busy}, 64'd1);
    next_cycle();
    check("wr_busy_after", {63'd0, busy}, 64'd0);

    // r1 read of the written word; r0_rdata must stay at its reset value.
    issue(1'b1, 1'b0, 8'h10, 32'h0, 32'hDEADBEEF);
    wait_idle();
    check("rd_r1_rdata", {32'd0, r1_rdata}, {32'd0, 32'hDEADBEEF});
    check("rd_r0_untouched", {32'd0, r0_rdata}, 64'd0);

    // Preload two words, then both requesters read continuously: grants 0,1,0,1.
    issue(1'b0, 1'b1, 8'h20, 32'h11112222, 32'h0);
    wait_idle();
    issue(1'b1, 1'b1, 8'h30, 32'h33334444, 32'h0);
    wait_idle();
    n = cyc;
    r0_req = 1'b1; r0_wr = 1'b0; r0_addr = 8'h20; r0_wdata = 32'h0;
    r1_req = 1'b1; r1_wr = 1'b0; r1_addr = 8'h30; r1_wdata = 32'h0;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(ev(n + 5 * k + 1, 1'b0, k[0], 1'b0, k[0] ? 8'h30 : 8'h20, 32'h0));
      exp_q.push_back(ev(n + 5 * k + 4, 1'b1, k[0], 1'b0, 8'h00, k[0] ? 32'h33334444 : 32'h11112222));
    end
    repeat (17) next_cycle();
    r0_req = 1'b0;
    r1_req = 1'b0;
    wait_idle();
    check("fair_r0_rdata", {32'd0, r0_rdata}, {32'd0, 32'h11112222});
    check("fair_r1_rdata", {32'd0, r1_rdata}, {32'd0, 32'h33334444});

    // r0 pulses only while the FSM is in WAIT: it must be ignored.
    issue(1'b1, 1'b0, 8'h30, 32'h0, 32'h33334444);
    next_cycle();
    r0_req = 1'b1; r0_wr = 1'b0; r0_addr = 8'h10;
    next_cycle();
    r0_req = 1'b0;
    repeat (5) next_cycle();
    check("pulse_ignored_busy", {63'd0, busy}, 64'd0);
    check("pulse_r0_rdata", {32'd0, r0_rdata}, {32'd0, 32'h11112222});

    // r1 write whose req drops right after sampling still completes.
    issue(1'b1, 1'b1, 8'h40, 32'hCAFEF00D, 32'h0);
    wait_idle();
    issue(1'b0, 1'b0, 8'h40, 32'h0, 32'hCAFEF00D);
    wait_idle();
    check("wr_keeps_r1_rdata", {32'd0, r1_rdata}, {32'd0, 32'h33334444});
    check("rd_after_r1_wr", {32'd0, r0_rdata}, {32'd0, 32'hCAFEF00D});

    // Let the RD_LAT=1/7 instances finish before the shared reset is pulsed.
    for (int i = 0; i < 200 && !(g_lat[0].done && g_lat[1].done); i++) next_cycle();
    check("lat_instances_done", {62'd0, g_lat[1].done, g_lat[0].done}, 64'd3);

    // Reset while in WAIT: outputs clear at once and the read never returns.
    wait_idle();
    n = cyc;
    r0_req = 1'b1; r0_wr = 1'b0; r0_addr = 8'h10; r0_wdata = 32'h0;
    exp_q.push_back(ev(n + 1, 1'b0, 1'b0, 1'b0, 8'h10, 32'h0));
    next_cycle();
    r0_req = 1'b0;
    next_cycle();
    check("pre_reset_in_wait", {62'd0, dbg_state}, 64'd2);
    reset = 1'b1;
    #1;
    check_all_zero("mid_reset");
    next_cycle();
    reset = 1'b0;
    repeat (6) next_cycle();
    check("post_reset_idle", {63'd0, busy}, 64'd0);

    // After reset requester 0 wins the first tie; back-to-back writes two cycles apart.
    n = cyc;
    r0_req = 1'b1; r0_wr = 1'b1; r0_addr = 8'h50; r0_wdata = 32'h00000005;
    r1_req = 1'b1; r1_wr = 1'b1; r1_addr = 8'h51; r1_wdata = 32'h00000006;
    exp_q.push_back(ev(n + 1, 1'b0, 1'b0, 1'b1, 8'h50, 32'h00000005));
    exp_q.push_back(ev(n + 3, 1'b0, 1'b1, 1'b1, 8'h51, 32'h00000006));
    next_cycle();
    r0_req = 1'b0;
    repeat (2) next_cycle();
    r1_req = 1'b0;
    wait_idle();
    repeat (5) next_cycle();
    check("main_drain", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
